// File: rtl/chunked_seq_adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
package chunked_seq_adder_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} cs_state_t;

    // Chunk counter width; at least one bit even for a single chunk.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for the chunked sequential adder.
interface chunked_seq_adder_if #(
    parameter int unsigned W = 32
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_seq_adder_ripple_adder.sv
// M-bit ripple-carry adder used as the per-chunk datapath.
module ripple_adder #(
    parameter int unsigned m = 4
) (
    input  logic [m-1:0] a,
    input  logic [m-1:0] b,
    input  logic         ci,
    output logic [m-1:0] s,
    output logic         co
);

    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < int'(m); i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/chunked_seq_adder.sv
// Wide adder that reuses one M-bit ripple adder over W/M cycles,
// shifting chunk sums into the result register LSB chunk first.
module chunked_seq_adder
    import chunked_seq_adder_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned M = 4
) (
    input  logic               clk,
    input  logic               rst,
    chunked_seq_adder_if.slave bus
);

    localparam int unsigned N  = W / M;
    localparam int unsigned CW = cnt_width(N);

    if ((W % M) != 0 || W < M) begin : g_bad_params
        $error("chunked_seq_adder: W must be a non-zero multiple of M");
    end

    cs_state_t       state, state_n;
    logic [W-1:0]    op_a, op_b, res, res_shift;
    logic            carry, a_msb, b_msb;
    logic [CW-1:0]   cnt;
    logic            cout_q, ovf_q, in_ready_q, out_valid_q;
    logic [M-1:0]    chunk_s;
    logic            chunk_co;
    logic            last;

    ripple_adder #(.m(M)) u_add (
        .a  (op_a[M-1:0]),
        .b  (op_b[M-1:0]),
        .ci (carry),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // New chunk enters at the top; after N shifts the LSB chunk is at bit 0.
    if (N == 1) begin : g_single
        assign res_shift = chunk_s;
    end else begin : g_multi
        assign res_shift = {chunk_s, res[W-1:M]};
    end

    assign last = (cnt == CW'(N - 1));

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.in_valid && in_ready_q) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            res         <= '0;
            carry       <= 1'b0;
            a_msb       <= 1'b0;
            b_msb       <= 1'b0;
            cnt         <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_n;
            in_ready_q  <= (state_n == IDLE);
            out_valid_q <= (state_n == DONE);
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        op_a  <= bus.a;
                        op_b  <= bus.b;
                        carry <= bus.cin;
                        a_msb <= bus.a[W-1];
                        b_msb <= bus.b[W-1];
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    res   <= res_shift;
                    op_a  <= op_a >> M;
                    op_b  <= op_b >> M;
                    carry <= chunk_co;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cout_q <= chunk_co;
                        ovf_q  <= (a_msb == b_msb) && (chunk_s[M-1] != a_msb);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = res;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed and random checks of chunked_seq_adder at W/M = 16/4, 4/4, 32/8.
module tb_chunked_seq_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    chunked_seq_adder_if #(.W(16)) if16 ();
    chunked_seq_adder_if #(.W(4))  if4 ();
    chunked_seq_adder_if #(.W(32)) if32 ();

    chunked_seq_adder #(.W(16), .M(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    chunked_seq_adder #(.W(4),  .M(4)) dut4  (.clk(clk), .rst(rst), .bus(if4));
    chunked_seq_adder #(.W(32), .M(8)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operation on the 16-bit instance; operands are scrambled after accept.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci,
                        output logic [15:0] s, output logic co, output logic ov,
                        output int lat);
        int guard = 0;
        while (!if16.in_ready && guard < 40) begin tick(); guard++; end
        if16.a = a; if16.b = b; if16.cin = ci; if16.in_valid = 1'b1;
        tick();
        if16.in_valid = 1'b0; if16.a = 16'hDEAD; if16.b = 16'hBEEF; if16.cin = ~ci;
        lat = 0;
        while (!if16.out_valid && lat < 40) begin tick(); lat++; end
        s = if16.sum; co = if16.cout; ov = if16.ovf;
        if16.out_ready = 1'b1;
        tick();
        if16.out_ready = 1'b0;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic ci,
                       output logic [3:0] s, output logic co, output logic ov,
                       output int lat);
        int guard = 0;
        while (!if4.in_ready && guard < 40) begin tick(); guard++; end
        if4.a = a; if4.b = b; if4.cin = ci; if4.in_valid = 1'b1;
        tick();
        if4.in_valid = 1'b0; if4.a = 4'h5; if4.b = 4'hA; if4.cin = ~ci;
        lat = 0;
        while (!if4.out_valid && lat < 40) begin tick(); lat++; end
        s = if4.sum; co = if4.cout; ov = if4.ovf;
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
    endtask

    task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        output logic [31:0] s, output logic co, output logic ov,
                        output int lat);
        int guard = 0;
        while (!if32.in_ready && guard < 40) begin tick(); guard++; end
        if32.a = a; if32.b = b; if32.cin = ci; if32.in_valid = 1'b1;
        tick();
        if32.in_valid = 1'b0; if32.a = ~a; if32.b = ~b; if32.cin = ~ci;
        lat = 0;
        while (!if32.out_valid && lat < 40) begin tick(); lat++; end
        s = if32.sum; co = if32.cout; ov = if32.ovf;
        if32.out_ready = 1'b1;
        tick();
        if32.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if (if16.in_ready !== 1'b0 || if16.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b, required 0 0", if16.in_ready, if16.out_valid);
        end
        tests++;
        if (if16.sum !== 16'h0 || if16.cout !== 1'b0 || if16.ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_out: sum=%h cout=%b ovf=%b, required 0000 0 0", if16.sum, if16.cout, if16.ovf);
        end
        rst = 1'b0;
        tick();
        tests++;
        if ({if16.in_ready, if4.in_ready, if32.in_ready} !== 3'b111) begin
            fails++;
            $display("FAIL reset_release: in_ready=%b%b%b, required 111", if16.in_ready, if4.in_ready, if32.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] va [4] = '{16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] vb [4] = '{16'h0001, 16'h0001, 16'h0000, 16'h8000};
        logic        vc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [15:0] es [4] = '{16'h0100, 16'h0000, 16'h8000, 16'h0000};
        logic        eco[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        eov[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            op16(va[i], vb[i], vc[i], s, co, ov, lat);
            tests++;
            if (lat !== 4) begin
                fails++;
                $display("FAIL basic_latency[%0d]: %0d cycles, required 4", i, lat);
            end
            tests++;
            if (s !== es[i]) begin
                fails++;
                $display("FAIL basic_sum[%0d]: sum=%h, required %h", i, s, es[i]);
            end
            tests++;
            if (co !== eco[i] || ov !== eov[i]) begin
                fails++;
                $display("FAIL basic_flags[%0d]: cout=%b ovf=%b, required %b %b", i, co, ov, eco[i], eov[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] s;
        logic        co, ov;
        int          lat;
        if16.a = 16'h1234; if16.b = 16'h4321; if16.cin = 1'b0; if16.in_valid = 1'b1;
        tick();
        if16.in_valid = 1'b0;
        lat = 0;
        while (!if16.out_valid && lat < 40) begin tick(); lat++; end
        tests++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL bp_latency: %0d cycles, required 4", lat);
        end
        if16.a = 16'h0001; if16.b = 16'h0002; if16.cin = 1'b0; if16.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (if16.out_valid !== 1'b1 || if16.sum !== 16'h5555 || if16.in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: out_valid=%b sum=%h in_ready=%b, required 1 5555 0",
                         i, if16.out_valid, if16.sum, if16.in_ready);
            end
            tick();
        end
        if16.out_ready = 1'b1;
        tick();
        if16.out_ready = 1'b0;
        tests++;
        if (if16.out_valid !== 1'b0 || if16.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", if16.out_valid, if16.in_ready);
        end
        tick();
        if16.in_valid = 1'b0;
        tests++;
        if (if16.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_next_accept: in_ready=%b, required 0", if16.in_ready);
        end
        lat = 0;
        while (!if16.out_valid && lat < 40) begin tick(); lat++; end
        s = if16.sum;
        if16.out_ready = 1'b1;
        tick();
        if16.out_ready = 1'b0;
        tests++;
        if (s !== 16'h0003 || lat !== 4) begin
            fails++;
            $display("FAIL bp_next_sum: sum=%h lat=%0d, required 0003 4", s, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen = 0;
        if16.a = 16'hFFFF; if16.b = 16'hFFFF; if16.cin = 1'b1; if16.in_valid = 1'b1;
        tick();
        if16.in_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (if16.out_valid !== 1'b0 || if16.sum !== 16'h0 || if16.cout !== 1'b0 || if16.ovf !== 1'b0) begin
            fails++;
            $display("FAIL midrun_outputs: out_valid=%b sum=%h cout=%b ovf=%b, required 0 0000 0 0",
                     if16.out_valid, if16.sum, if16.cout, if16.ovf);
        end
        tick();
        tests++;
        if (if16.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrun_ready: in_ready=%b, required 1", if16.in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            if (if16.out_valid) seen++;
            tick();
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL midrun_no_valid: out_valid seen %0d cycles, required 0", seen);
        end
    endtask

    task automatic test_degenerate();
        logic [3:0] s;
        logic       co, ov;
        int         lat;
        op4(4'hF, 4'h1, 1'b0, s, co, ov, lat);
        tests++;
        if (lat !== 1) begin
            fails++;
            $display("FAIL n1_latency: %0d cycles, required 1", lat);
        end
        tests++;
        if (s !== 4'h0 || co !== 1'b1 || ov !== 1'b0) begin
            fails++;
            $display("FAIL n1_result: sum=%h cout=%b ovf=%b, required 0 1 0", s, co, ov);
        end
        op4(4'h7, 4'h0, 1'b1, s, co, ov, lat);
        tests++;
        if (s !== 4'h8 || co !== 1'b0 || ov !== 1'b1 || lat !== 1) begin
            fails++;
            $display("FAIL n1_ovf: sum=%h cout=%b ovf=%b lat=%0d, required 8 0 1 1", s, co, ov, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, s, es;
        logic        ci, co, ov, eco, eov;
        logic [32:0] full;
        int          lat;
        for (int i = 0; i < 1000; i++) begin
            a  = $urandom();
            b  = $urandom();
            ci = 1'($urandom_range(1));
            if (i == 0) begin a = 32'hFFFF_FFFF; b = 32'h0; ci = 1'b1; end
            if (i == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; ci = 1'b0; end
            full = 33'(a) + 33'(b) + 33'(ci);
            es   = full[31:0];
            eco  = full[32];
            eov  = (a[31] == b[31]) && (es[31] != a[31]);
            op32(a, b, ci, s, co, ov, lat);
            tests++;
            if ({s, co, ov} !== {es, eco, eov} || lat !== 4) begin
                fails++;
                $display("FAIL rand[%0d]: %h+%h+%b gave sum=%h cout=%b ovf=%b lat=%0d, required %h %b %b 4",
                         i, a, b, ci, s, co, ov, lat, es, eco, eov);
            end
        end
    endtask

    initial begin
        if16.in_valid = 1'b0; if16.out_ready = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0;
        if4.in_valid  = 1'b0; if4.out_ready  = 1'b0; if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0;
        if32.in_valid = 1'b0; if32.out_ready = 1'b0; if32.a = '0; if32.b = '0; if32.cin = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_run();
        test_degenerate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
